// File: rtl/ysyx_22050019_pkg.sv
// Shared definitions for the ysyx_22050019 fetch path: FSM states, AXI
// response codes and the architectural reset PC.
package ysyx_22050019_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2
  } ifu_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [63:0] IFU_RESET_VAL = 64'h8000_0000;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_22050019_ifu_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst, err} entries.
// Flush wins over push and pop; storage itself is never reset.
module ysyx_22050019_ifu_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ysyx_22050019_ifu_axi.sv
// Fetch unit: owns the PC, issues one AXI read at a time and queues returned
// instructions toward IDU. EXU redirects flush the queue and drop in-flight data.
module ysyx_22050019_ifu_axi
  import ysyx_22050019_pkg::*;
#(
  parameter int          ADDR_W     = 64,
  parameter int          INST_W     = 32,
  parameter logic [63:0] RESET_VAL  = IFU_RESET_VAL,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [INST_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_err
);

  localparam int ENTRY_W = ADDR_W + INST_W + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_RST = RESET_VAL[ADDR_W-1:0];

  ifu_state_e        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              discard;
  logic              armed;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ENTRY_W-1:0] push_entry;
  logic               slot_free;

  assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign push_entry   = {ar_addr, r_data, resp_is_err(r_resp)};
  assign fifo_push    = (state == IFU_WAIT) && r_valid && !discard && !redirect_valid;
  assign fifo_pop     = out_valid && out_ready;
  // An entry leaving this cycle frees a slot for the next request.
  assign slot_free    = (fifo_count - CNT_W'(fifo_pop)) < CNT_W'(FIFO_DEPTH);

  assign out_valid = !fifo_empty;
  assign {out_pc, out_inst, out_err} = out_valid ? fifo_head : '0;

  ysyx_22050019_ifu_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // armed holds off the first request by one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IFU_IDLE;
      pc       <= PC_RST;
      ar_addr  <= PC_RST;
      ar_valid <= 1'b0;
      r_ready  <= 1'b0;
      discard  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (redirect_valid) pc <= redirect_tgt;
      case (state)
        IFU_IDLE: begin
          if (!redirect_valid && armed && slot_free) begin
            state    <= IFU_REQ;
            ar_valid <= 1'b1;
            ar_addr  <= pc;
          end
        end
        IFU_REQ: begin
          if (redirect_valid) discard <= 1'b1;
          if (ar_ready) begin
            state    <= IFU_WAIT;
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            // A redirect seen during this request already owns the PC.
            if (!redirect_valid && !discard) pc <= pc + ADDR_W'(4);
          end
        end
        IFU_WAIT: begin
          if (r_valid) begin
            state   <= IFU_IDLE;
            r_ready <= 1'b0;
            discard <= 1'b0;
          end else if (redirect_valid) begin
            discard <= 1'b1;
          end
        end
        default: state <= IFU_IDLE;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_ysyx_22050019_ifu_axi.sv
// Directed bench for the AXI fetch unit with a transaction-level reference model.
module tb_ysyx_22050019_ifu_axi;
  import ysyx_22050019_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [63:0] ar_addr;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        out_valid, out_err;
  logic        out_ready = 1'b1;
  logic [63:0] out_pc;
  logic [31:0] out_inst;

  always #5 clk = ~clk;

  ysyx_22050019_ifu_axi #(
    .ADDR_W(64), .INST_W(32), .RESET_VAL(64'h8000_0000), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_err(out_err)
  );

  // Memory: one pending read, data is a fixed function of the address.
  logic        ar_ready_en = 1'b1;
  logic        r_en = 1'b1;
  logic        mem_pend;
  logic [63:0] mem_addr = '0;
  logic [63:0] err_addr = '1;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_BEEF;
  endfunction

  assign ar_ready = ar_ready_en;
  assign r_valid  = mem_pend && r_en;
  assign r_data   = inst_of(mem_addr);
  assign r_resp   = (mem_addr == err_addr) ? RESP_SLVERR : RESP_OKAY;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_pend <= 1'b0;
    else begin
      if (r_valid && r_ready) mem_pend <= 1'b0;
      if (ar_valid && ar_ready) begin
        mem_pend <= 1'b1;
        mem_addr <= ar_addr;
      end
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } ent_t;

  ent_t        mq[$];
  ent_t        pop_log[$];
  logic [63:0] ar_log[$];

  logic [63:0] m_pc = RST_PC;
  bit          m_locked = 0;
  logic [63:0] m_locked_addr = '0;
  bit          ob_valid = 0, ob_discard = 0;
  logic [63:0] ob_addr = '0;
  bit          stall_prev = 0;
  logic [63:0] stall_addr = '0;

  // Reference model: fetch order, redirect/discard rules, and buffer contents.
  always @(posedge clk) begin : model
    bit   ar_hs, r_hs, pop, push_ok;
    ent_t e, p;
    if (!rst_n) begin
      mq.delete();
      m_pc = RST_PC;
      m_locked = 0;
      ob_valid = 0;
      ob_discard = 0;
      stall_prev = 0;
    end else begin
      ar_hs = ar_valid && ar_ready;
      r_hs = r_valid && r_ready;
      pop = out_valid && out_ready;
      push_ok = 0;
      if (r_hs) begin
        push_ok = ob_valid && !ob_discard && !redirect_valid;
        e.pc = ob_addr;
        e.inst = inst_of(ob_addr);
        e.err = (ob_addr == err_addr);
        ob_valid = 0;
      end
      if (ar_hs) begin
        ar_log.push_back(ar_addr);
        if (m_locked) begin
          chk("ar_addr_locked", ar_addr, m_locked_addr);
          ob_discard = 1;
          m_locked = 0;
        end else begin
          chk("ar_addr_seq", ar_addr, m_pc);
          ob_discard = redirect_valid;
          if (!redirect_valid) m_pc = m_pc + 64'd4;
        end
        ob_valid = 1;
        ob_addr = ar_addr;
      end
      if (pop && !redirect_valid) begin
        p.pc = out_pc;
        p.inst = out_inst;
        p.err = out_err;
        pop_log.push_back(p);
      end
      if (redirect_valid) begin
        mq.delete();
        m_pc = {redirect_pc[63:2], 2'b00};
        if (ar_valid && !ar_ready) begin
          m_locked = 1;
          m_locked_addr = ar_addr;
        end
        if (ob_valid) ob_discard = 1;
      end else begin
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (push_ok) mq.push_back(e);
      end
      stall_prev = ar_valid && !ar_ready;
      stall_addr = ar_addr;
      #1;
      if (rst_n) begin
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
          chk("out_pc", out_pc, mq[0].pc);
          chk("out_inst", 64'(out_inst), 64'(mq[0].inst));
          chk("out_err", 64'(out_err), 64'(mq[0].err));
        end else begin
          chk("out_pc_empty", out_pc, 64'd0);
          chk("out_inst_empty", 64'(out_inst), 64'd0);
        end
        if (stall_prev) begin
          chk("ar_hold_valid", 64'(ar_valid), 64'd1);
          chk("ar_hold_addr", ar_addr, stall_addr);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("rst_r_ready", 64'(r_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_ar_addr", ar_addr, RST_PC);
    ar_log.delete();
    pop_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_pops(input int n, input string name);
    int k = 0;
    while (pop_log.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(pop_log.size() >= n), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int k;
    @(negedge clk);

    // Zero-wait memory, sequential fetch and first-response latency.
    do_reset();
    @(posedge clk); #1 chk("lat_e1_ar_valid", 64'(ar_valid), 64'd0);
    @(posedge clk); #1 chk("lat_e2_ar_valid", 64'(ar_valid), 64'd1);
    chk("lat_e2_ar_addr", ar_addr, RST_PC);
    @(posedge clk); #1 chk("lat_e3_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1 chk("lat_e4_out_valid", 64'(out_valid), 64'd1);
    chk("lat_e4_out_pc", out_pc, RST_PC);
    @(negedge clk);
    wait_pops(3, "seq_pops");
    chk("seq_ar0", ar_log[0], 64'h8000_0000);
    chk("seq_ar1", ar_log[1], 64'h8000_0004);
    chk("seq_ar2", ar_log[2], 64'h8000_0008);
    chk("seq_pc1", pop_log[1].pc, 64'h8000_0004);
    chk("seq_inst0", 64'(pop_log[0].inst), 64'h5EAD_BEEF);
    chk("seq_inst2", 64'(pop_log[2].inst), 64'h5EAD_BEE7);

    // Back-pressure: only FIFO_DEPTH reads, then one per freed slot.
    out_ready = 1'b0;
    do_reset();
    repeat (40) @(negedge clk);
    chk("bp_reads", 64'(ar_log.size()), 64'd2);
    chk("bp_ar_idle", 64'(ar_valid), 64'd0);
    chk("bp_head", out_pc, RST_PC);
    ar_log.delete();
    pop_log.delete();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("bp_one_read", 64'(ar_log.size()), 64'd1);
    chk("bp_one_addr", ar_log[0], 64'h8000_0008);
    chk("bp_one_pop", 64'(pop_log.size()), 64'd1);
    chk("bp_new_head", out_pc, 64'h8000_0004);

    // Redirect in WAIT with the response arriving in the same cycle.
    out_ready = 1'b1;
    do_reset();
    wait_pops(2, "rw_warmup");
    k = 0;
    while (!(r_valid && r_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rw_in_wait", 64'(r_valid && r_ready), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_1002;
    ar_log.delete();
    pop_log.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rw_flushed", 64'(out_valid), 64'd0);
    wait_pops(1, "rw_pops");
    chk("rw_ar", ar_log[0], 64'h8000_1000);
    chk("rw_pc", pop_log[0].pc, 64'h8000_1000);
    chk("rw_inst", 64'(pop_log[0].inst), 64'h5EAD_AEEF);

    // Redirect in REQ while ar_ready is held low for three cycles.
    ar_ready_en = 1'b0;
    do_reset();
    k = 0;
    while (!ar_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rq_req_addr", ar_addr, RST_PC);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_2000;
    ar_log.delete();
    pop_log.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("rq_hold_valid", 64'(ar_valid), 64'd1);
      chk("rq_hold_addr", ar_addr, RST_PC);
    end
    ar_ready_en = 1'b1;
    wait_pops(1, "rq_pops");
    chk("rq_ar_old", ar_log[0], RST_PC);
    chk("rq_ar_new", ar_log[1], 64'h8000_2000);
    chk("rq_pc", pop_log[0].pc, 64'h8000_2000);

    // Error response is delivered in order and fetching continues.
    err_addr = 64'h8000_0004;
    do_reset();
    wait_pops(3, "err_pops");
    chk("err_e0", 64'(pop_log[0].err), 64'd0);
    chk("err_pc1", pop_log[1].pc, 64'h8000_0004);
    chk("err_e1", 64'(pop_log[1].err), 64'd1);
    chk("err_pc2", pop_log[2].pc, 64'h8000_0008);
    chk("err_e2", 64'(pop_log[2].err), 64'd0);
    err_addr = '1;

    // PC wrap at the top of the address space, then reset mid-WAIT.
    out_ready = 1'b0;
    repeat (30) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    ar_log.delete();
    pop_log.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    k = 0;
    while (ar_log.size() < 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    r_en = 1'b0;
    chk("wrap_ar0", ar_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_ar1", ar_log[1], 64'h0);
    chk("wrap_r_ready", 64'(r_ready), 64'd1);
    chk("wrap_out_valid", 64'(out_valid), 64'd1);
    chk("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ar_valid", 64'(ar_valid), 64'd0);
    chk("arst_r_ready", 64'(r_ready), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_ar_addr", ar_addr, RST_PC);
    r_en = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    ar_log.delete();
    pop_log.delete();
    rst_n = 1'b1;
    wait_pops(1, "arst_pops");
    chk("arst_restart_pc", pop_log[0].pc, RST_PC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050019_ifu_axi.md
Name: ysyx_22050019_ifu_axi

Overview:
- Parametrised fetch unit that replaces the single-register fetch stage.
- Holds the PC and issues instruction reads over an AXI-style AR/R handshake, one outstanding read at a time.
- Buffers returned instructions, each with its PC, in a small FIFO toward IDU with a valid/ready interface.
- Supports EXU redirects (branch/jump) that flush the buffer and discard any in-flight response.

Parameters:
- ADDR_W, 64, PC and fetch address width.
- INST_W, 32, instruction width.
- RESET_VAL, 64'h80000000, PC after reset (truncated to ADDR_W).
- FIFO_DEPTH, 2, fetch buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  redirect request from EXU.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] are ignored and forced to 0.
- ar_valid  out  1  read address valid.
- ar_ready  in  1  read address accepted.
- ar_addr  out  ADDR_W  fetch address.
- r_valid  in  1  read data valid.
- r_ready  out  1  read data accept.
- r_data  in  INST_W  instruction returned.
- r_resp  in  2  read response; any nonzero value is an error.
- out_valid  out  1  buffered instruction available.
- out_ready  in  1  IDU accepts the head entry.
- out_pc  out  ADDR_W  PC of the head entry.
- out_inst  out  INST_W  instruction of the head entry.
- out_err  out  1  head entry had a nonzero r_resp.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - state=IDLE, pc=RESET_VAL, ar_addr=RESET_VAL, ar_valid=0, r_ready=0.
  - FIFO empty, so out_valid=0 and out_pc/out_inst/out_err=0; discard=0.
  - Reset mid-transaction abandons the transaction. The bench must reset the memory model together with the IFU.
- FSM states:
  - IDLE: if FIFO count < FIFO_DEPTH (pops this cycle counted as free), go to REQ next cycle with ar_addr=pc, ar_valid=1.
  - REQ: ar_valid=1; ar_valid and ar_addr stay stable until ar_ready. On handshake, pc<=pc+4 (modulo 2^ADDR_W, wraps silently) and go to WAIT.
  - WAIT: r_ready=1. On r_valid, push {ar_addr, r_data, |r_resp} into the FIFO unless discard=1; clear discard; go to IDLE.
- Latency:
  - First ar_valid appears the 2nd rising edge after reset deasserts (IDLE→REQ).
  - Response accepted at edge N gives out_valid=1 after edge N.
  - Steady-state throughput: one instruction per 3 cycles with zero-wait memory.
- Space reservation:
  - A request is only issued when a FIFO slot is free, so a WAIT push never overflows. r_ready is never throttled.
  - Simultaneous push and pop at full is legal; count is unchanged.
- FIFO output: out_* reflect the head entry combinationally from the FIFO storage. A pop occurs when out_valid && out_ready.
- Redirect (highest priority, takes effect at the edge where it is sampled):
  - FIFO flushed; out_valid=0 after the edge. A same-cycle pop and push are both ignored.
  - pc<=redirect_pc&~3.
  - IDLE: next request uses the new pc.
  - REQ: ar_valid stays asserted with the old ar_addr until ar_ready (protocol rule); discard<=1. The pc increment at handshake is suppressed in the redirect cycle and later.
  - WAIT: discard<=1. If r_valid arrives in the same cycle, the response is dropped.
  - Back-to-back redirects: the last one wins.
- Error responses are stored normally with out_err=1. The IFU neither stalls nor retries; the trap decision belongs downstream.

Decomposition:
- Shared package ysyx_22050019_pkg:
  - IFU state encoding localparams (IDLE/REQ/WAIT).
  - AXI resp codes (OKAY=2'b00, SLVERR, DECERR).
  - Default RESET_VAL.
- Sub-module ysyx_22050019_ifu_fifo:
  - Parametrised WIDTH/DEPTH synchronous FIFO with push/pop/flush, count and full/empty.
  - Flush has priority over push/pop.
  - Instantiated once with WIDTH=ADDR_W+INST_W+1.

Test Plan:
- Reset release, memory with ar_ready=r_valid=1 and zero wait, out_ready=1 → ar_addr sequence 0x80000000, 0x80000004, 0x80000008. out_pc follows in order with matching out_inst; first out_valid is 4 cycles after reset release.
- out_ready=0 with FIFO_DEPTH=2 → exactly 2 reads issued, ar_valid stays 0 afterwards. Raising out_ready for 1 cycle → exactly 1 new request issued.
- Redirect to 0x80001002 while in WAIT, with r_valid in the same cycle → that response is dropped and FIFO emptied. Next ar_addr=0x80001000, and next out_pc=0x80001000.
- Redirect while in REQ with ar_ready held low 3 cycles → ar_valid/ar_addr stay at the old address until handshake. The response is discarded; the following request targets the redirect pc.
- r_resp=2'b10 on the fetch at 0x80000004 → entry delivered with out_err=1 and out_pc=0x80000004. Fetching continues at 0x80000008.
- pc=0xFFFFFFFFFFFFFFFC fetched → next ar_addr=0x0 (wrap). Asserting rst_n=0 mid-WAIT → ar_valid, r_ready and out_valid drop immediately (asynchronously); pc=RESET_VAL.
